// File: rtl/cpu_core_pkg.sv
// Shared definitions for the multicycle CPU core: default widths, load-op codes
// and the write-back FSM state encoding.
package cpu_core_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LWL = 3'b010;
  localparam logic [2:0] LD_LW  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LWR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wbState_e;

endpackage

// File: rtl/load_align.sv
// Combinational load-data extraction, alignment and extension (little-endian).
// Merging lwl/lwr loads exist only when WB_UNALIGNED_LOAD_EN is defined.
module load_align
  import cpu_core_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [2:0]            op_i,
  input  logic [1:0]            offset_i,
  input  logic [DATA_WIDTH-1:0] memWord_i,
  input  logic [DATA_WIDTH-1:0] oldWord_i,
  output logic [DATA_WIDTH-1:0] aligned_o
);

  logic [DATA_WIDTH-1:0] byteShifted;
  logic [DATA_WIDTH-1:0] halfShifted;
  logic [7:0]            byteSel;
  logic [15:0]           halfSel;

  always_comb begin
    byteShifted = memWord_i >> {offset_i, 3'b000};
    halfShifted = memWord_i >> {offset_i[1], 4'b0000};
    byteSel     = byteShifted[7:0];
    halfSel     = halfShifted[15:0];
  end

`ifdef WB_UNALIGNED_LOAD_EN
  logic [4:0] lwlShift;
  logic [4:0] lwrShift;

  // lwl keeps the low 8*(3-o) bits of the old value; lwr keeps the high 8*o bits.
  always_comb begin
    lwlShift = {~offset_i, 3'b000};
    lwrShift = {offset_i, 3'b000};
  end
`else
  logic unusedOldWord;
  assign unusedOldWord = ^oldWord_i;
`endif

  always_comb begin
    aligned_o = memWord_i;
    case (op_i)
      LD_LB:   aligned_o = {{(DATA_WIDTH-8){byteSel[7]}}, byteSel};
      LD_LBU:  aligned_o = {{(DATA_WIDTH-8){1'b0}}, byteSel};
      LD_LH:   aligned_o = {{(DATA_WIDTH-16){halfSel[15]}}, halfSel};
      LD_LHU:  aligned_o = {{(DATA_WIDTH-16){1'b0}}, halfSel};
`ifdef WB_UNALIGNED_LOAD_EN
      LD_LWL:  aligned_o = (memWord_i << lwlShift)
                         | (oldWord_i & ~({DATA_WIDTH{1'b1}} << lwlShift));
      LD_LWR:  aligned_o = (memWord_i >> lwrShift)
                         | (oldWord_i & ~({DATA_WIDTH{1'b1}} >> lwrShift));
`endif
      default: aligned_o = memWord_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: takes ALU results or waits for load data, then issues a
// registered one-cycle register-file write. Optional macro: WB_UNALIGNED_LOAD_EN.
module wb_stage
  import cpu_core_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_op,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_old_rt,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_valid,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy
);

  wbState_e              state_q, state_d;
  logic                  accept;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            ldOp_q, ldOp_d;
  logic [1:0]            addrLo_q, addrLo_d;
  logic [DATA_WIDTH-1:0] oldForAlign;
  logic [DATA_WIDTH-1:0] alignedData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_MEM: if (mem_rdata_valid) state_d = ST_WRITE;
      default: begin
        if (accept) state_d = in_is_load ? ST_WAIT_MEM : ST_WRITE;
        else        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready = (state_q != ST_WAIT_MEM);
    busy     = (state_q == ST_WAIT_MEM);
  end

  assign accept = in_valid & in_ready;

  // waddr_q doubles as the captured destination while a load is outstanding.
  always_comb begin
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    ldOp_d   = ldOp_q;
    addrLo_d = addrLo_q;
    if (accept) begin
      waddr_d = in_waddr;
      if (in_is_load) begin
        ldOp_d   = in_load_op;
        addrLo_d = in_addr_lo;
      end else begin
        wen_d   = (in_waddr != '0);
        wdata_d = in_alu_result;
      end
    end else if (state_q == ST_WAIT_MEM && mem_rdata_valid) begin
      wen_d   = (waddr_q != '0);
      wdata_d = alignedData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      ldOp_q   <= LD_LW;
      addrLo_q <= 2'b00;
    end else begin
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      ldOp_q   <= ldOp_d;
      addrLo_q <= addrLo_d;
    end
  end

`ifdef WB_UNALIGNED_LOAD_EN
  logic [DATA_WIDTH-1:0] oldRt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          oldRt_q <= '0;
    else if (accept && in_is_load)    oldRt_q <= in_old_rt;
  end

  assign oldForAlign = oldRt_q;
`else
  logic unusedOldRt;
  assign unusedOldRt = ^in_old_rt;
  assign oldForAlign = '0;
`endif

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .op_i      (ldOp_q),
    .offset_i  (addrLo_q),
    .memWord_i (mem_rdata),
    .oldWord_i (oldForAlign),
    .aligned_o (alignedData)
  );

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// ALU/load traffic checked against a byte-level load model.
module tb_wb_stage;
  import cpu_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_waddr;
  logic        in_is_load;
  logic [2:0]  in_load_op;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic [31:0] in_old_rt;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;

  wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_waddr        (in_waddr),
    .in_is_load      (in_is_load),
    .in_load_op      (in_load_op),
    .in_addr_lo      (in_addr_lo),
    .in_alu_result   (in_alu_result),
    .in_old_rt       (in_old_rt),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .wen             (wen),
    .waddr           (waddr),
    .wdata           (wdata),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Reference load model built byte by byte from the little-endian rules.
  function automatic logic [31:0] modelLoad(input logic [2:0] op, input int o,
                                            input logic [31:0] mem, input logic [31:0] old);
    int         v;
    logic [7:0] mb [4];
    logic [7:0] ob [4];
    logic [7:0] rb [4];
    for (int i = 0; i < 4; i++) begin
      mb[i] = mem[8*i +: 8];
      ob[i] = old[8*i +: 8];
    end
    case (op)
      3'b000: begin v = int'(mb[o]); if (v >= 128) v = v - 256; return 32'(v); end
      3'b100: return 32'(int'(mb[o]));
      3'b001: begin
        v = int'(mb[(o / 2) * 2]) + 256 * int'(mb[(o / 2) * 2 + 1]);
        if (v >= 32768) v = v - 65536;
        return 32'(v);
      end
      3'b101: return 32'(int'(mb[(o / 2) * 2]) + 256 * int'(mb[(o / 2) * 2 + 1]));
`ifdef WB_UNALIGNED_LOAD_EN
      3'b010: begin
        for (int i = 0; i < 4; i++) rb[i] = (i >= 3 - o) ? mb[i - (3 - o)] : ob[i];
        return {rb[3], rb[2], rb[1], rb[0]};
      end
      3'b110: begin
        for (int i = 0; i < 4; i++) rb[i] = (i <= 3 - o) ? mb[i + o] : ob[i];
        return {rb[3], rb[2], rb[1], rb[0]};
      end
`endif
      default: return mem;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic isLoad, input logic [4:0] addr,
                               input logic [2:0] op, input logic [1:0] lo,
                               input logic [31:0] alu, input logic [31:0] old);
    in_valid      = valid;
    in_is_load    = isLoad;
    in_waddr      = addr;
    in_load_op    = op;
    in_addr_lo    = lo;
    in_alu_result = alu;
    in_old_rt     = old;
  endtask

  task automatic runAlu(input logic [4:0] addr, input logic [31:0] data, input string tag);
    applyStimulus(1'b1, 1'b0, addr, 3'($urandom), 2'($urandom), data, $urandom);
    checkOutput({tag, " ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput({tag, " wen"}, 32'(wen), 32'(addr != 5'd0));
    if (addr != 5'd0) begin
      checkOutput({tag, " waddr"}, 32'(waddr), 32'(addr));
      checkOutput({tag, " wdata"}, wdata, data);
    end
    step();
    checkOutput({tag, " wen drop"}, 32'(wen), 32'd0);
  endtask

  task automatic runLoad(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] mem,
                         input logic [31:0] old, input logic [4:0] addr, input int waitCycles,
                         input logic [31:0] expData, input string tag);
    applyStimulus(1'b1, 1'b1, addr, op, lo, $urandom, old);
    checkOutput({tag, " ready"}, 32'(in_ready), 32'd1);
    step();
    applyStimulus(1'b0, 1'b0, 5'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom);
    for (int i = 0; i < waitCycles; i++) begin
      if (i > 0) step();
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " ready low"}, 32'(in_ready), 32'd0);
      checkOutput({tag, " no wen"}, 32'(wen), 32'd0);
    end
    mem_rdata       = mem;
    mem_rdata_valid = 1'b1;
    step();
    mem_rdata_valid = 1'b0;
    mem_rdata       = $urandom;
    checkOutput({tag, " wen"}, 32'(wen), 32'(addr != 5'd0));
    checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
    if (addr != 5'd0) begin
      checkOutput({tag, " waddr"}, 32'(waddr), 32'(addr));
      checkOutput({tag, " wdata"}, wdata, expData);
    end
    step();
    checkOutput({tag, " wen drop"}, 32'(wen), 32'd0);
  endtask

  initial begin
    logic [31:0] expLwl;
    logic [31:0] expLwr;
    logic [31:0] rMem;
    logic [31:0] rOld;
    logic [2:0]  rOp;
    logic [1:0]  rLo;
    logic [4:0]  rAddr;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0, 32'd0);
    mem_rdata       = 32'd0;
    mem_rdata_valid = 1'b0;
    #1;
    checkOutput("reset wen", 32'(wen), 32'd0);
    checkOutput("reset waddr", 32'(waddr), 32'd0);
    checkOutput("reset wdata", wdata, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    runAlu(5'd5, 32'h12345678, "alu r5");

    runLoad(LD_LB, 2'd3, 32'h80FF0011, 32'h0, 5'd3, 1, 32'hFFFFFF80, "lb o3");
    runLoad(LD_LBU, 2'd3, 32'h80FF0011, 32'h0, 5'd4, 1, 32'h00000080, "lbu o3");
    runLoad(LD_LH, 2'd2, 32'h80011234, 32'h0, 5'd6, 3, 32'hFFFF8001, "lh o2");
    runLoad(LD_LHU, 2'd2, 32'h80011234, 32'h0, 5'd6, 3, 32'h00008001, "lhu o2");

    // Register 0 followed back-to-back by register 7.
    applyStimulus(1'b1, 1'b0, 5'd0, 3'd0, 2'd0, 32'hDEADBEEF, 32'd0);
    step();
    checkOutput("r0 no wen", 32'(wen), 32'd0);
    checkOutput("b2b ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd7, 3'd0, 2'd0, 32'hCAFEF00D, 32'd0);
    step();
    in_valid = 1'b0;
    checkOutput("r7 wen", 32'(wen), 32'd1);
    checkOutput("r7 waddr", 32'(waddr), 32'd7);
    checkOutput("r7 wdata", wdata, 32'hCAFEF00D);
    step();
    checkOutput("r7 wen drop", 32'(wen), 32'd0);

`ifdef WB_UNALIGNED_LOAD_EN
    expLwl = 32'hCCDD3344;
    expLwr = 32'h11AABBCC;
`else
    expLwl = 32'hAABBCCDD;
    expLwr = 32'hAABBCCDD;
`endif
    runLoad(LD_LWL, 2'd1, 32'hAABBCCDD, 32'h11223344, 5'd8, 2, expLwl, "lwl o1");
    runLoad(LD_LWR, 2'd1, 32'hAABBCCDD, 32'h11223344, 5'd8, 2, expLwr, "lwr o1");

    // Stray memory valid while idle must not produce a write.
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'h55555555;
    step();
    mem_rdata_valid = 1'b0;
    checkOutput("stray valid wen", 32'(wen), 32'd0);
    checkOutput("stray valid busy", 32'(busy), 32'd0);

    // Reset in the middle of a load wait.
    applyStimulus(1'b1, 1'b1, 5'd9, LD_LW, 2'd0, 32'd0, 32'd0);
    step();
    in_valid = 1'b0;
    checkOutput("abort busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort wen", 32'(wen), 32'd0);
    checkOutput("abort waddr", 32'(waddr), 32'd0);
    checkOutput("abort wdata", wdata, 32'd0);
    checkOutput("abort busy clr", 32'(busy), 32'd0);
    checkOutput("abort ready", 32'(in_ready), 32'd1);
    step();
    rst             = 1'b0;
    mem_rdata       = 32'h76543210;
    mem_rdata_valid = 1'b1;
    step();
    mem_rdata_valid = 1'b0;
    checkOutput("post abort wen", 32'(wen), 32'd0);
    step();
    checkOutput("post abort wen2", 32'(wen), 32'd0);
    checkOutput("post abort busy", 32'(busy), 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      rAddr = 5'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        runAlu(rAddr, $urandom, "rand alu");
      end else begin
        rOp  = 3'($urandom);
        rLo  = 2'($urandom);
        rMem = $urandom;
        rOld = $urandom;
        runLoad(rOp, rLo, rMem, rOld, rAddr, int'($urandom_range(1, 4)),
                modelLoad(rOp, int'(rLo), rMem, rOld), "rand load");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the multicycle CPU core. It accepts a completed instruction result from execute, or waits for load data from memory, and extracts, aligns and extends the load data. It drives the register file write port (`wen`/`waddr`/`wdata`) with a registered, single-cycle write pulse. It sits directly upstream of the register file and closes the datapath loop.

## Interface
Parameters:
- `DATA_WIDTH`, 32: datapath width.
- `ADDR_WIDTH`, 5: register index width.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  execute offers an instruction result.
- `in_ready`  out  1  stage accepts the offer this cycle.
- `in_waddr`  in  ADDR_WIDTH  destination register.
- `in_is_load`  in  1  result comes from memory, not from `in_alu_result`.
- `in_load_op`  in  3  load type: 000 lb, 001 lh, 010 lwl, 011 lw, 100 lbu, 101 lhu, 110 lwr, 111 treated as lw.
- `in_addr_lo`  in  2  byte offset of the load address.
- `in_alu_result`  in  DATA_WIDTH  non-load result.
- `in_old_rt`  in  DATA_WIDTH  current destination value, used for merging by lwl/lwr.
- `mem_rdata`  in  DATA_WIDTH  memory read word.
- `mem_rdata_valid`  in  1  `mem_rdata` is valid this cycle.
- `wen`  out  1  register file write enable.
- `waddr`  out  ADDR_WIDTH  register file write address.
- `wdata`  out  DATA_WIDTH  register file write data.
- `busy`  out  1  a load is outstanding.

## Operation
- FSM states:
  - IDLE: no result pending.
  - WAIT_MEM: load outstanding.
  - WRITE: write pulse active.
- `in_ready` = (state != WAIT_MEM). `busy` = (state == WAIT_MEM).
- Handshake: a transfer happens when `in_valid & in_ready`.
- Non-load accept: go to WRITE.
  - Register `wen`=(`in_waddr`!=0), `waddr`=`in_waddr`, `wdata`=`in_alu_result`.
- Load accept: go to WAIT_MEM.
  - Capture `in_waddr`, `in_load_op`, `in_addr_lo` and `in_old_rt`. `wen` is 0.
- WAIT_MEM on `mem_rdata_valid`: go to WRITE.
  - Register the aligned data and `wen`=(captured waddr!=0).
- WRITE: `wen` is held for exactly one cycle.
  - Next state is IDLE, or the state implied by an accept in the same cycle. Back-to-back accepts are allowed.
- `mem_rdata_valid` outside WAIT_MEM is ignored.
- Writes to register 0 complete the handshake but never assert `wen`.
- Alignment is little-endian; o = offset.
  - lb/lbu: byte o, sign- or zero-extended.
  - lh/lhu: halfword at `o[1]`, extended; `o[0]` is ignored.
  - lw: the whole word.
  - lwl: `(mem << 8*(3-o)) | (old & low 8*(3-o) bits)`.
  - lwr: `(mem >> 8*o) | (old & high 8*o bits)`.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - `wen`=0, `waddr`=0, `wdata`=0.
  - `busy`=0, `in_ready`=1.
- Latency:
  - ALU result accepted in cycle N gives `wen` in cycle N+1.
  - `mem_rdata_valid` in cycle M gives `wen` in cycle M+1.
- Memory wait length is unbounded; `in_ready` stays 0 throughout.
- Reset during WAIT_MEM aborts the load: no write occurs, and a later `mem_rdata_valid` is ignored.
- Accept and `mem_rdata_valid` cannot coincide, because `in_ready` is 0 in WAIT_MEM.

## Configuration
- `WB_UNALIGNED_LOAD_EN`:
  - Defined: lwl/lwr merge as above.
  - Undefined: ops 010 and 110 behave as lw, and `in_old_rt` is unused; its capture register is removed.

## Structure
- Shared package `cpu_core_pkg`:
  - Load-op encoding constants (`LD_LB`...`LD_LWR`).
  - FSM state encoding.
  - `DATA_WIDTH`/`ADDR_WIDTH` defaults.
- Sub-module `load_align`: purely combinational.
  - Inputs: op, offset, mem word, old value.
  - Output: aligned word.
  - Holds the macro-dependent logic.

## Test plan
- Reset, then ALU result with `in_waddr`=5, `in_alu_result`=0x12345678 -> next cycle `wen`=1, `waddr`=5, `wdata`=0x12345678. The next cycle `wen`=0.
- lb with o=3, `mem_rdata`=0x80FF0011 -> `wdata`=0xFFFFFF80. lbu with the same inputs -> 0x00000080.
- lh with o=2, data valid 3 cycles after accept, `mem_rdata`=0x80011234:
  - `in_ready`=0 and `busy`=1 for the 3 wait cycles.
  - `wdata`=0xFFFF8001. lhu gives 0x00008001.
- ALU result to register 0, back-to-back with an ALU result to register 7 -> no `wen` for register 0, then `wen`=1 for register 7 one cycle later.
- lwl o=1, `mem_rdata`=0xAABBCCDD, `in_old_rt`=0x11223344 -> 0xCCDD3344. lwr o=1 with the same inputs -> 0x11AABBCC. With the macro undefined, both give 0xAABBCCDD.
- Assert `rst` mid-WAIT_MEM, then pulse `mem_rdata_valid` after reset -> outputs go to 0 immediately, and no `wen` follows.
